// File: rtl/spad_arb.sv
// Two-requester round-robin arbiter in front of the scratchpad ar/r/aw channels,
// with an in-order tag FIFO steering read data back. Option: SPAD_ARB_WR_PRIO_EN.
module spad_arb #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 256,
    parameter int OST_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [1:0]            req_valid_i,
    output logic [1:0]            req_ready_o,
    input  logic [1:0]            req_we_i,
    input  logic [2*ADDR_W-1:0]   req_addr_i,
    input  logic [2*DATA_W-1:0]   req_wdata_i,

    output logic [1:0]            rsp_valid_o,
    input  logic [1:0]            rsp_ready_i,
    output logic [DATA_W-1:0]     rsp_data_o,

    output logic                  spad_ar_valid_o,
    input  logic                  spad_ar_ready_i,
    output logic [ADDR_W-1:0]     spad_ar_addr_o,

    input  logic                  spad_r_valid_i,
    output logic                  spad_r_ready_o,
    input  logic [DATA_W-1:0]     spad_r_data_i,

    output logic                  spad_aw_valid_o,
    input  logic                  spad_aw_ready_i,
    output logic [ADDR_W-1:0]     spad_aw_addr_o,
    output logic [DATA_W-1:0]     spad_aw_data_o,

    output logic                  err_o
);

    localparam int PTR_W = $clog2(OST_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic                 rr;
    logic [OST_DEPTH-1:0] tag_mem;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 err_q;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 head_tag;
    logic [1:0]           elig;
    logic                 any_elig;
    logic                 win;
    logic                 win_we;
    logic [ADDR_W-1:0]    win_addr;
    logic [DATA_W-1:0]    win_data;
    logic                 ar_hs;
    logic                 aw_hs;
    logic                 r_hs;
    logic                 push;
    logic                 pop;

    assign fifo_full  = (count == CNT_W'(OST_DEPTH));
    assign fifo_empty = (count == '0);
    assign head_tag   = tag_mem[rd_ptr];

    // A full tag FIFO masks reads only; a same-cycle pop does not bypass it.
    always_comb begin
        elig = '0;
        for (int i = 0; i < 2; i++) begin
            elig[i] = req_valid_i[i] & (req_we_i[i] | ~fifo_full);
        end
    end

    // The winner is a pure function of rr and the eligible set, so it stays put
    // while a request waits on ready.
    always_comb begin
        win = rr;
        case (elig)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11: begin
`ifdef SPAD_ARB_WR_PRIO_EN
                if (req_we_i[0] != req_we_i[1]) begin
                    win = req_we_i[1];
                end else begin
                    win = rr;
                end
`else
                win = rr;
`endif
            end
            default: win = rr;
        endcase
    end

    assign any_elig = |elig;
    assign win_we   = win ? req_we_i[1] : req_we_i[0];
    assign win_addr = win ? req_addr_i[ADDR_W +: ADDR_W] : req_addr_i[0 +: ADDR_W];
    assign win_data = win ? req_wdata_i[DATA_W +: DATA_W] : req_wdata_i[0 +: DATA_W];

    assign spad_ar_valid_o = any_elig & ~win_we;
    assign spad_ar_addr_o  = spad_ar_valid_o ? win_addr : '0;
    assign spad_aw_valid_o = any_elig & win_we;
    assign spad_aw_addr_o  = spad_aw_valid_o ? win_addr : '0;
    assign spad_aw_data_o  = spad_aw_valid_o ? win_data : '0;

    assign ar_hs = spad_ar_valid_o & spad_ar_ready_i;
    assign aw_hs = spad_aw_valid_o & spad_aw_ready_i;

    always_comb begin
        req_ready_o = 2'b00;
        if (ar_hs | aw_hs) begin
            req_ready_o = win ? 2'b10 : 2'b01;
        end
    end

    // With no outstanding tag the r channel sinks and drops whatever arrives.
    always_comb begin
        rsp_valid_o    = 2'b00;
        rsp_data_o     = '0;
        spad_r_ready_o = 1'b1;
        if (!fifo_empty) begin
            rsp_data_o     = spad_r_data_i;
            spad_r_ready_o = head_tag ? rsp_ready_i[1] : rsp_ready_i[0];
            if (spad_r_valid_i) begin
                rsp_valid_o = head_tag ? 2'b10 : 2'b01;
            end
        end
    end

    assign r_hs = spad_r_valid_i & spad_r_ready_o;
    assign push = ar_hs;
    assign pop  = r_hs & ~fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr     <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (ar_hs | aw_hs) begin
                rr <= ~win;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (spad_r_valid_i && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    // Tag storage carries no reset; only slots between rd_ptr and wr_ptr are read.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= win;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_spad_arb.sv
// Bench for spad_arb: directed scenarios plus constrained-random traffic,
// all checked against a queue-based model of the arbitration and tag rules.
module tb_spad_arb;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 256;
    localparam int OST_DEPTH = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_we;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [DATA_W-1:0]   rsp_data;
    logic                ar_valid, ar_ready;
    logic [ADDR_W-1:0]   ar_addr;
    logic                r_valid, r_ready;
    logic [DATA_W-1:0]   r_data;
    logic                aw_valid, aw_ready;
    logic [ADDR_W-1:0]   aw_addr;
    logic [DATA_W-1:0]   aw_data;
    logic                err;

    int checks = 0;
    int errors = 0;

    spad_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OST_DEPTH(OST_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .spad_ar_valid_o(ar_valid), .spad_ar_ready_i(ar_ready), .spad_ar_addr_o(ar_addr),
        .spad_r_valid_i(r_valid), .spad_r_ready_o(r_ready), .spad_r_data_i(r_data),
        .spad_aw_valid_o(aw_valid), .spad_aw_ready_i(aw_ready),
        .spad_aw_addr_o(aw_addr), .spad_aw_data_o(aw_data),
        .err_o(err)
    );

    always #5 clk = ~clk;

    // Reference model state: priority holder, outstanding read owners, sticky error.
    bit m_rr;
    bit m_q[$];
    bit m_err;

    int                e_win;
    logic [1:0]        e_ready;
    logic              e_ar_v, e_aw_v, e_r_ready;
    logic [ADDR_W-1:0] e_ar_addr, e_aw_addr;
    logic [DATA_W-1:0] e_aw_data, e_rsp_data;
    logic [1:0]        e_rsp_v;
    logic [1:0]        last_ready;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] v;
        for (int k = 0; k < DATA_W / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_eval();
        bit full;
        bit el[2];
        bit h;
        full = (m_q.size() >= OST_DEPTH);
        for (int i = 0; i < 2; i++) el[i] = req_valid[i] && (req_we[i] || !full);
        if (el[0] && el[1]) begin
`ifdef SPAD_ARB_WR_PRIO_EN
            if (req_we[0] && !req_we[1])      e_win = 0;
            else if (req_we[1] && !req_we[0]) e_win = 1;
            else                              e_win = m_rr ? 1 : 0;
`else
            e_win = m_rr ? 1 : 0;
`endif
        end else if (el[0]) e_win = 0;
        else if (el[1])     e_win = 1;
        else                e_win = -1;

        e_ready = 2'b00; e_ar_v = 1'b0; e_aw_v = 1'b0;
        e_ar_addr = '0; e_aw_addr = '0; e_aw_data = '0;
        if (e_win >= 0) begin
            if (req_we[e_win]) begin
                e_aw_v    = 1'b1;
                e_aw_addr = req_addr[e_win*ADDR_W +: ADDR_W];
                e_aw_data = req_wdata[e_win*DATA_W +: DATA_W];
                if (aw_ready) e_ready[e_win] = 1'b1;
            end else begin
                e_ar_v    = 1'b1;
                e_ar_addr = req_addr[e_win*ADDR_W +: ADDR_W];
                if (ar_ready) e_ready[e_win] = 1'b1;
            end
        end

        e_rsp_v = 2'b00; e_rsp_data = '0; e_r_ready = 1'b1;
        if (m_q.size() > 0) begin
            h = m_q[0];
            e_rsp_v[h] = r_valid;
            e_r_ready  = rsp_ready[h];
            e_rsp_data = r_data;
        end
    endtask

    task automatic model_update();
        bit do_pop;
        bit was_empty;
        was_empty = (m_q.size() == 0);
        do_pop    = r_valid && e_r_ready && !was_empty;
        if (r_valid && was_empty) m_err = 1'b1;
        if (do_pop) void'(m_q.pop_front());
        if (e_ready != 2'b00) begin
            if (e_ar_v) m_q.push_back(e_win == 1);
            m_rr = (e_win == 0);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
        chk("req_ready", req_ready, e_ready);
        chk("ar_valid", ar_valid, e_ar_v);
        chk("ar_addr", ar_addr, e_ar_addr);
        chk("aw_valid", aw_valid, e_aw_v);
        chk("aw_addr", aw_addr, e_aw_addr);
        chk("aw_data", aw_data, e_aw_data);
        chk("rsp_valid", rsp_valid, e_rsp_v);
        chk("rsp_data", rsp_data, e_rsp_data);
        chk("r_ready", r_ready, e_r_ready);
        chk("err", err, m_err);
    endtask

    task automatic adv();
        @(posedge clk);
        if (rst_n) model_update();
        #1;
    endtask

    task automatic step();
        settle();
        adv();
    endtask

    task automatic idle_inputs();
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        rsp_ready = '0; ar_ready = 1'b0; aw_ready = 1'b0;
        r_valid = 1'b0; r_data = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        m_rr = 1'b0; m_q.delete(); m_err = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        #1;
        do_reset();
        step();

        // Alternating grants: both read, data returns one cycle after issue.
        req_valid = 2'b11; req_we = 2'b00;
        req_addr  = {32'h0000_0200, 32'h0000_0100};
        ar_ready  = 1'b1; rsp_ready = 2'b11;
        for (int k = 0; k < 8; k++) begin
            r_valid = (m_q.size() > 0);
            r_data  = rand_data();
            settle();
            chk("alt_grant", req_ready, (k % 2) ? 2'b10 : 2'b01);
            if (k > 0) chk("alt_rsp", rsp_valid, ((k - 1) % 2) ? 2'b10 : 2'b01);
            adv();
        end

        // Backpressure holds the winner.
        do_reset();
        req_valid = 2'b11; req_we = 2'b10;
        req_addr  = {32'h0000_0020, 32'h0000_0010};
        req_wdata = {rand_data(), rand_data()};
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("bp_noready", req_ready, 2'b00);
`ifdef SPAD_ARB_WR_PRIO_EN
            chk("bp_aw_held", {aw_valid, aw_addr}, {1'b1, 32'h20});
`else
            chk("bp_ar_held", {ar_valid, ar_addr}, {1'b1, 32'h10});
`endif
            adv();
        end
        ar_ready = 1'b1; aw_ready = 1'b1;
        settle();
`ifdef SPAD_ARB_WR_PRIO_EN
        chk("bp_grant", req_ready, 2'b10);
`else
        chk("bp_grant", req_ready, 2'b01);
`endif
        adv();

        // Full FIFO blocks reads, writes still go.
        do_reset();
        req_valid = 2'b01; req_we = 2'b00; ar_ready = 1'b1; aw_ready = 1'b1;
        for (int k = 0; k < OST_DEPTH; k++) begin
            req_addr[0 +: ADDR_W] = 32'h1000 + k;
            step();
        end
        req_valid = 2'b11; req_we = 2'b10; req_addr[0 +: ADDR_W] = 32'h2000;
        req_wdata = {rand_data(), rand_data()};
        settle();
        chk("full_ar_blocked", ar_valid, 1'b0);
        chk("full_aw_issues", {aw_valid, req_ready}, {1'b1, 2'b10});
        adv();
        req_valid = 2'b01; r_valid = 1'b1; rsp_ready = 2'b11; r_data = rand_data();
        settle();
        chk("full_no_bypass", ar_valid, 1'b0);
        chk("full_pop", r_ready, 1'b1);
        adv();
        r_valid = 1'b0;
        settle();
        chk("full_read_after_pop", {ar_valid, ar_addr}, {1'b1, 32'h2000});
        adv();

        // Response backpressure with head tag 1.
        do_reset();
        req_valid = 2'b10; req_we = 2'b00; req_addr = {32'h0000_0300, 32'h0};
        ar_ready = 1'b1;
        step();
        req_valid = 2'b00; r_valid = 1'b1; rsp_ready = 2'b01; r_data = rand_data();
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("rbp_ready_low", r_ready, 1'b0);
            chk("rbp_valid", rsp_valid, 2'b10);
            adv();
        end
        rsp_ready = 2'b11;
        settle();
        chk("rbp_pop", r_ready, 1'b1);
        adv();
        r_valid = 1'b0;
        step();

        // Unexpected data with an empty FIFO.
        r_valid = 1'b1; r_data = rand_data();
        settle();
        chk("unexp_drop", {rsp_valid, r_ready}, {2'b00, 1'b1});
        adv();
        r_valid = 1'b0;
        settle();
        chk("unexp_err_set", err, 1'b1);
        adv();
        step();
        chk("unexp_err_sticky", err, 1'b1);

        // Reset with three reads outstanding.
        do_reset();
        req_valid = 2'b01; req_we = 2'b00; ar_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_addr[0 +: ADDR_W] = 32'h4000 + k;
            step();
        end
        req_valid = 2'b10;
        req_addr  = {32'h0000_5000, 32'h0};
        step();
        do_reset();
        rsp_ready = 2'b00;
        settle();
        chk("rst_fifo_empty", {r_ready, err}, {1'b1, 1'b0});
        adv();
        req_valid = 2'b11; req_we = 2'b00; ar_ready = 1'b1;
        req_addr  = {32'h0000_6100, 32'h0000_6000};
        settle();
        chk("rst_rr_zero", req_ready, 2'b01);
        adv();

        // Constrained-random traffic honouring the hold-until-ready rule.
        do_reset();
        last_ready = 2'b00;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!(req_valid[i] && !last_ready[i])) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    req_we[i]    = 1'($urandom_range(0, 1));
                    req_addr[i*ADDR_W +: ADDR_W]  = $urandom;
                    req_wdata[i*DATA_W +: DATA_W] = rand_data();
                end
            end
            ar_ready  = ($urandom_range(0, 3) != 0);
            aw_ready  = ($urandom_range(0, 3) != 0);
            rsp_ready = 2'($urandom_range(0, 3));
            r_valid   = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
            r_data    = rand_data();
            step();
            last_ready = e_ready;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
